// File: rtl/ntt_bank_wb_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_bank_wb_ctrl
//
// Write-back controller for the 16-bank NTT data memory. Address beats from
// the AGU (per-lane bank number + memory address) are queued in a tag FIFO.
// Each returning butterfly result beat pops the head. A lane-to-bank crossbar
// then produces registered per-bank write strobes, addresses and data.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   BN_MA_out_en    address beat valid; pushes MA_idx/BN_idx into the FIFO
//   AGU_done_out    1-cycle pulse; the AGU has issued its last beat
//   MA_idx          lane i address at [i*MA_W +: MA_W]
//   BN_idx          lane i bank at    [i*BN_W +: BN_W]
//   bf_valid        butterfly result valid; pops the FIFO head
//   bf_data         lane i result at  [i*DW +: DW]
//   bank_wen        per-bank write enable (registered, 1-cycle strobe)
//   bank_waddr      per-bank write address (holds when bank not hit)
//   bank_wdata      per-bank write data    (holds when bank not hit)
//   fifo_full/empty FIFO status from the registered occupancy
//   wb_done         1-cycle pulse when the stage write-back completes
//   overflow_err, underflow_err, conflict_err   sticky, cleared by rst
//
// Configuration macro
//   NTT_WB_CONFLICT_CHECK_EN  compiles in the bank-conflict comparator tree;
//                             when undefined conflict_err is tied to 0.
// ---------------------------------------------------------------------------
module ntt_bank_wb_ctrl #(
    parameter int MA_W  = 6,
    parameter int BN_W  = 4,
    parameter int DW    = 64,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               BN_MA_out_en,
    input  logic               AGU_done_out,
    input  logic [16*MA_W-1:0] MA_idx,
    input  logic [16*BN_W-1:0] BN_idx,
    input  logic               bf_valid,
    input  logic [16*DW-1:0]   bf_data,
    output logic [15:0]        bank_wen,
    output logic [16*MA_W-1:0] bank_waddr,
    output logic [16*DW-1:0]   bank_wdata,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic               wb_done,
    output logic               overflow_err,
    output logic               underflow_err,
    output logic               conflict_err
);

    localparam int NL = 16;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nx;

    // ------------------------------------------------------------------
    // Address-tag FIFO
    // ------------------------------------------------------------------
    logic [16*BN_W-1:0] bn_mem [DEPTH];
    logic [16*MA_W-1:0] ma_mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;

    logic is_empty, is_full, do_pop, do_push;

    assign is_empty = (count == '0);
    assign is_full  = (count == (AW+1)'(DEPTH));
    // An empty FIFO never pops, even if a push arrives the same cycle.
    assign do_pop   = bf_valid && !is_empty;
    // A full FIFO accepts a push only when a pop frees a slot this cycle.
    assign do_push  = BN_MA_out_en && (!is_full || do_pop);

    assign fifo_empty = is_empty;
    assign fifo_full  = is_full;

    // NOTE: the tag storage has no reset; count and pointers alone define
    // which entries are valid, so clearing the array would only cost area.
    always_ff @(posedge clk) begin
        if (do_push) begin
            bn_mem[wr_ptr] <= BN_idx;
            ma_mem[wr_ptr] <= MA_idx;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    logic [16*BN_W-1:0] head_bn;
    logic [16*MA_W-1:0] head_ma;

    assign head_bn = bn_mem[rd_ptr];
    assign head_ma = ma_mem[rd_ptr];

    // ------------------------------------------------------------------
    // Lane-to-bank crossbar
    // ------------------------------------------------------------------
    logic [NL-1:0]      hit;
    logic [16*MA_W-1:0] sel_addr;
    logic [16*DW-1:0]   sel_data;

    // NOTE: every always_comb output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        hit      = '0;
        sel_addr = '0;
        sel_data = '0;
        idx      = 0;
        // Scan high-to-low: the lowest matching lane is assigned last and wins.
        for (int i = NL - 1; i >= 0; i--) begin
            idx = int'(head_bn[i*BN_W +: BN_W]);
            hit[idx]                    = 1'b1;
            sel_addr[idx*MA_W +: MA_W]  = head_ma[i*MA_W +: MA_W];
            sel_data[idx*DW +: DW]      = bf_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_wen   <= '0;
            bank_waddr <= '0;
            bank_wdata <= '0;
        end else begin
            bank_wen <= do_pop ? hit : '0;
            if (do_pop) begin
                for (int b = 0; b < NL; b++) begin
                    if (hit[b]) begin
                        bank_waddr[b*MA_W +: MA_W] <= sel_addr[b*MA_W +: MA_W];
                        bank_wdata[b*DW +: DW]     <= sel_data[b*DW +: DW];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (BN_MA_out_en && is_full && !bf_valid) overflow_err <= 1'b1;
            if (bf_valid && is_empty)                 underflow_err <= 1'b1;
        end
    end

`ifdef NTT_WB_CONFLICT_CHECK_EN
    logic head_conflict;

    // Pairwise comparator tree over all lanes of the head beat.
    always_comb begin
        head_conflict = 1'b0;
        for (int i = 0; i < NL; i++) begin
            for (int j = i + 1; j < NL; j++) begin
                if (head_bn[i*BN_W +: BN_W] == head_bn[j*BN_W +: BN_W])
                    head_conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            conflict_err <= 1'b0;
        else if (do_pop && head_conflict)
            conflict_err <= 1'b1;
    end
`else
    assign conflict_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (AGU_done_out)      state_nx = DRAIN;
                else if (BN_MA_out_en) state_nx = RUN;
            end
            RUN: begin
                if (AGU_done_out) state_nx = DRAIN;
            end
            DRAIN: begin
                // A push into an empty FIFO still holds the drain open.
                if (is_empty && !do_pop && !BN_MA_out_en) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wb_done = 1'b0;
        if (state == DONE) wb_done = 1'b1;
    end

endmodule
